mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port, variable-latency memory between the pipelined CPU's
//   instruction fetch (IF) and data access (MEM stage, load/store).
//   Three-state FSM with fixed data-over-fetch priority and a starvation guard.
//   Returns per-requester read data with an ack pulse, and drives stall
//   outputs that the PC / pipe registers use to freeze.
// PARAMETERS
//   ADDR_W        32  address width, both requesters and memory
//   DATA_W        32  data width
//   STARVE_LIMIT  4   consecutive IF losses before IF is forced to win (>=1)
// PORTS
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       reset, asynchronous, active-low
//   if_req_i     in   1       fetch request; held with if_addr_i until if_ack_o
//   if_addr_i    in   ADDR_W  fetch address
//   if_ack_o     out  1       one-cycle pulse: if_rdata_o valid
//   if_rdata_o   out  DATA_W  fetched instruction, held until next IF ack
//   dm_req_i     in   1       data request; held with addr/we/wdata until dm_ack_o
//   dm_we_i      in   1       1 = store, 0 = load
//   dm_addr_i    in   ADDR_W  data address
//   dm_wdata_i   in   DATA_W  store data
//   dm_ack_o     out  1       one-cycle pulse: access complete
//   dm_rdata_o   out  DATA_W  load data, held until next DM load ack
//   mem_req_o    out  1       memory request, held until mem_ready_i
//   mem_we_o     out  1       memory write enable
//   mem_addr_o   out  ADDR_W  memory address
//   mem_wdata_o  out  DATA_W  memory write data
//   mem_ready_i  in   1       memory completes access this cycle
//   mem_rdata_i  in   DATA_W  read data, valid with mem_ready_i
//   stall_if_o   out  1       if_req_i & ~if_ack_o (combinational)
//   stall_dm_o   out  1       dm_req_i & ~dm_ack_o (combinational)
// BEHAVIOUR
//   Reset (async, rst_i=0): state IDLE, all registered outputs 0,
//     rdata registers 0, starve_cnt 0. Reset mid-access abandons it, no ack.
//   States: IDLE, IF_BUSY, DM_BUSY.
//   IDLE, decision each cycle:
//     - dm only -> DM_BUSY.
//     - if only -> IF_BUSY.
//     - both, starve_cnt <  STARVE_LIMIT -> DM_BUSY, starve_cnt+1.
//     - both, starve_cnt == STARVE_LIMIT -> IF_BUSY.
//     - neither -> stay.
//     - Any IF grant clears starve_cnt.
//   Grant edge registers: mem_req_o=1, mem_addr_o/mem_we_o/mem_wdata_o.
//     IF grants use we=0 and wdata=0.
//     All stay constant for the whole busy state.
//   X_BUSY, mem_ready_i=0: hold everything. No timeout.
//   X_BUSY, mem_ready_i=1:
//     - Next edge: -> IDLE, mem_req_o=0, mem_addr_o/mem_we_o/mem_wdata_o=0.
//     - x_ack_o=1 for exactly that one cycle.
//     - Reads: x_rdata_o latches mem_rdata_i.
//     - DM store: dm_rdata_o is unchanged.
//   Latency: req seen in IDLE at edge N -> mem_req_o high after N.
//     mem_ready_i at edge M -> ack high after M. Min 2 cycles, ready same cycle.
//   Ack cycle is an IDLE cycle, so a new grant is possible in it. A requester
//     still asserting req during its ack is treated as a new request.
//     Back-to-back: one access every 2 cycles per memory.
//   Requests arriving while busy wait in IDLE arbitration; no queueing.
//   starve_cnt width $clog2(STARVE_LIMIT+1); it never exceeds STARVE_LIMIT.
//   mem_ready_i in IDLE is ignored.
// TESTING
//   1 Reset: rst_i=0 mid-DM_BUSY -> all outputs 0 asynchronously, no dm_ack_o
//     after release.
//   2 IF read: if_req_i=1, addr 0x10, ready 3 cycles after mem_req_o, rdata
//     0x8C010004 -> if_ack_o 1 cycle, if_rdata_o=0x8C010004, stall_if_o high
//     until ack.
//   3 Contention: both req every cycle, ready same cycle, STARVE_LIMIT=4
//     -> grant order DM,DM,DM,DM,IF,DM,...
//   4 Store: dm_we_i=1, addr 0x20, wdata 0xDEADBEEF -> mem_we_o=1 with those
//     values, stable until ready; dm_rdata_o keeps its prior load value.
//   5 Held ready: mem_ready_i tied 1, IF req held high -> if_ack_o pulses
//     every 2nd cycle; mem_req_o never high in IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory between
// instruction fetch and data access. Data has fixed priority over fetch. A
// starvation counter forces a fetch grant after STARVE_LIMIT consecutive
// losses. Every memory-facing output and ack is registered. The stall outputs
// are combinational from the request inputs and the registered acks.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_dm_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               grant_if, grant_dm;
  logic               mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_d;
  logic               if_ack_d, dm_ack_d;
  logic [DATA_W-1:0]  if_rdata_d, dm_rdata_d;
  logic               starved;

  assign starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  // State register plus every registered output.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      if_ack_o     <= 1'b0;
      dm_ack_o     <= 1'b0;
      if_rdata_o   <= '0;
      dm_rdata_o   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_o    <= mem_req_d;
      mem_we_o     <= mem_we_d;
      mem_addr_o   <= mem_addr_d;
      mem_wdata_o  <= mem_wdata_d;
      if_ack_o     <= if_ack_d;
      dm_ack_o     <= dm_ack_d;
      if_rdata_o   <= if_rdata_d;
      dm_rdata_o   <= dm_rdata_d;
    end
  end

  // Next state: arbitrate in IDLE, wait for the memory in the busy states.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req_i && !(if_req_i && starved)) begin
          grant_dm = 1'b1;
          state_d  = DM_BUSY;
        end else if (if_req_i) begin
          grant_if = 1'b1;
          state_d  = IF_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: if (mem_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs. The memory bus is loaded on a
  // grant, held while busy and cleared on completion.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_if)
      starve_cnt_d = '0;
    else if (grant_dm && if_req_i)
      starve_cnt_d = starve_cnt_q + 1'b1;

    mem_req_d   = (state_d != IDLE);
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (grant_dm) begin
      mem_we_d    = dm_we_i;
      mem_addr_d  = dm_addr_i;
      mem_wdata_d = dm_wdata_i;
    end else if (grant_if) begin
      mem_addr_d  = if_addr_i;
    end else if (state_q != IDLE && !mem_ready_i) begin
      mem_we_d    = mem_we_o;
      mem_addr_d  = mem_addr_o;
      mem_wdata_d = mem_wdata_o;
    end

    if_ack_d   = (state_q == IF_BUSY) && mem_ready_i;
    dm_ack_d   = (state_q == DM_BUSY) && mem_ready_i;
    // A store completing must not overwrite the last load result.
    if_rdata_d = if_ack_d ? mem_rdata_i : if_rdata_o;
    dm_rdata_d = (dm_ack_d && !mem_we_o) ? mem_rdata_i : dm_rdata_o;
  end

  assign stall_if_o = if_req_i & ~if_ack_o;
  assign stall_dm_o = dm_req_i & ~dm_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, table-driven check of the memory port
// arbiter, plus hand-written sequences for reset, contention and held-ready.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, dm_req_i, dm_we_i, mem_ready_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_if_o, stall_dm_o;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
    .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i),
    .stall_if_o(stall_if_o), .stall_dm_o(stall_dm_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        e_mem_req, e_mem_we;
    logic [31:0] e_mem_addr, e_mem_wdata;
    logic        e_if_ack, e_dm_ack, e_stall_if, e_stall_dm;
    logic [31:0] e_if_rdata, e_dm_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
    logic [31:0] dd, logic rdy, logic [31:0] rd,
    logic emr, logic emw, logic [31:0] ema, logic [31:0] emd,
    logic eia, logic eda, logic esi, logic esd,
    logic [31:0] eir, logic [31:0] edr);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw;
    v.dm_addr = da; v.dm_wdata = dd; v.ready = rdy; v.rdata = rd;
    v.e_mem_req = emr; v.e_mem_we = emw; v.e_mem_addr = ema;
    v.e_mem_wdata = emd; v.e_if_ack = eia; v.e_dm_ack = eda;
    v.e_stall_if = esi; v.e_stall_dm = esd;
    v.e_if_rdata = eir; v.e_dm_rdata = edr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_we_i = 0;
    dm_addr_i = 0; dm_wdata_i = 0; mem_ready_i = 0; mem_rdata_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    rst_i = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1;
  endtask

  localparam logic [31:0] INS = 32'h8C01_0004;
  localparam logic [31:0] LD  = 32'h1122_3344;

  initial begin
    idle_inputs();
    rst_i = 0;
    #1;
    chk("rst.mem_req", {31'd0, mem_req_o}, 0);
    chk("rst.mem_addr", mem_addr_o, 0);
    chk("rst.if_ack", {31'd0, if_ack_o}, 0);
    chk("rst.if_rdata", if_rdata_o, 0);
    chk("rst.dm_rdata", dm_rdata_o, 0);
    @(negedge clk_i);
    rst_i = 1;

    // IF read with 3-cycle memory latency, ready in IDLE ignored, DM load,
    // then a store that must leave the load data intact.
    vecs.push_back(mk(1,32'h10,0,0,0,0, 0,0, 1,0,32'h10,0, 0,0,1,0, 0,0));
    vecs.push_back(mk(1,32'h10,0,0,0,0, 0,0, 1,0,32'h10,0, 0,0,1,0, 0,0));
    vecs.push_back(mk(1,32'h10,0,0,0,0, 0,0, 1,0,32'h10,0, 0,0,1,0, 0,0));
    vecs.push_back(mk(1,32'h10,0,0,0,0, 1,INS, 0,0,0,0, 1,0,0,0, INS,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0, INS,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h5555_5555, 0,0,0,0, 0,0,0,0, INS,0));
    vecs.push_back(mk(0,0,1,0,32'h24,0, 0,0, 1,0,32'h24,0, 0,0,0,1, INS,0));
    vecs.push_back(mk(0,0,1,0,32'h24,0, 1,LD, 0,0,0,0, 0,1,0,0, INS,LD));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0, INS,LD));
    vecs.push_back(mk(0,0,1,1,32'h20,32'hDEADBEEF, 0,0,
                      1,1,32'h20,32'hDEADBEEF, 0,0,0,1, INS,LD));
    vecs.push_back(mk(0,0,1,1,32'h20,32'hDEADBEEF, 0,0,
                      1,1,32'h20,32'hDEADBEEF, 0,0,0,1, INS,LD));
    vecs.push_back(mk(0,0,1,1,32'h20,32'hDEADBEEF, 1,32'hFFFF_FFFF,
                      0,0,0,0, 0,1,0,0, INS,LD));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0, INS,LD));

    foreach (vecs[i]) begin
      @(negedge clk_i);
      if_req_i = vecs[i].if_req; if_addr_i = vecs[i].if_addr;
      dm_req_i = vecs[i].dm_req; dm_we_i = vecs[i].dm_we;
      dm_addr_i = vecs[i].dm_addr; dm_wdata_i = vecs[i].dm_wdata;
      mem_ready_i = vecs[i].ready; mem_rdata_i = vecs[i].rdata;
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d.mem_req", i), {31'd0, mem_req_o}, {31'd0, vecs[i].e_mem_req});
      chk($sformatf("v%0d.mem_we", i), {31'd0, mem_we_o}, {31'd0, vecs[i].e_mem_we});
      chk($sformatf("v%0d.mem_addr", i), mem_addr_o, vecs[i].e_mem_addr);
      chk($sformatf("v%0d.mem_wdata", i), mem_wdata_o, vecs[i].e_mem_wdata);
      chk($sformatf("v%0d.if_ack", i), {31'd0, if_ack_o}, {31'd0, vecs[i].e_if_ack});
      chk($sformatf("v%0d.dm_ack", i), {31'd0, dm_ack_o}, {31'd0, vecs[i].e_dm_ack});
      chk($sformatf("v%0d.stall_if", i), {31'd0, stall_if_o}, {31'd0, vecs[i].e_stall_if});
      chk($sformatf("v%0d.stall_dm", i), {31'd0, stall_dm_o}, {31'd0, vecs[i].e_stall_dm});
      chk($sformatf("v%0d.if_rdata", i), if_rdata_o, vecs[i].e_if_rdata);
      chk($sformatf("v%0d.dm_rdata", i), dm_rdata_o, vecs[i].e_dm_rdata);
    end

    // Asynchronous reset in the middle of a DM store abandons it with no ack.
    @(negedge clk_i);
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h30; dm_wdata_i = 32'hA5A5_A5A5;
    mem_ready_i = 0;
    @(posedge clk_i);
    #1;
    chk("arst.pre_mem_req", {31'd0, mem_req_o}, 1);
    #2;
    rst_i = 0;
    #1;
    chk("arst.mem_req", {31'd0, mem_req_o}, 0);
    chk("arst.mem_we", {31'd0, mem_we_o}, 0);
    chk("arst.mem_addr", mem_addr_o, 0);
    chk("arst.mem_wdata", mem_wdata_o, 0);
    chk("arst.if_rdata", if_rdata_o, 0);
    chk("arst.dm_rdata", dm_rdata_o, 0);
    chk("arst.dm_ack", {31'd0, dm_ack_o}, 0);
    @(negedge clk_i);
    dm_req_i = 0; mem_ready_i = 1;
    @(negedge clk_i);
    rst_i = 1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i);
      #1;
      chk($sformatf("arst.no_ack%0d", c), {31'd0, dm_ack_o | mem_req_o}, 0);
    end

    // Contention with ready held: four DM grants, then one forced IF grant.
    do_reset();
    @(negedge clk_i);
    if_req_i = 1; if_addr_i = 32'h100;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h200; mem_ready_i = 1;
    begin
      logic [31:0] got[$];
      logic [31:0] exp_order[10];
      exp_order = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100,
                    32'h200, 32'h200, 32'h200, 32'h200, 32'h100};
      for (int c = 0; c < 40 && got.size() < 10; c++) begin
        @(posedge clk_i);
        #1;
        if (mem_req_o) got.push_back(mem_addr_o);
      end
      chk("cont.grant_count", got.size(), 10);
      for (int g = 0; g < 10 && g < got.size(); g++)
        chk($sformatf("cont.grant%0d", g), got[g], exp_order[g]);
    end

    // Ready tied high, IF held: ack on every 2nd cycle, never with mem_req.
    do_reset();
    @(negedge clk_i);
    if_req_i = 1; if_addr_i = 32'h40; mem_ready_i = 1; mem_rdata_i = 32'h77;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_i);
      #1;
      chk($sformatf("held.mem_req%0d", k), {31'd0, mem_req_o}, {31'd0, k[0]});
      chk($sformatf("held.if_ack%0d", k), {31'd0, if_ack_o}, {31'd0, ~k[0]});
    end
    chk("held.if_rdata", if_rdata_o, 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
